uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized serial input, centre-sampled 8N1-style frames,
// one-cycle word_valid / frame_err pulses, no back-pressure.
module uart_rx #(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_in,
  output logic [NUM_BITS-1:0] word_out,
  output logic                word_valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(NUM_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_sync1;
  logic                r_rx_s;
  logic                r_rx_d;
  logic [1:0]          r_flush;
  logic                r_armed;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [NUM_BITS-1:0] r_shift;
  logic [NUM_BITS-1:0] r_word;
  logic                r_valid;
  logic                r_ferr;
  logic                r_busy;
  logic                w_start;
  logic                w_cnt_clr;
  logic                w_idx_clr;
  logic                w_shift_en;
  logic                w_load;
  logic                w_ferr;

  // The synchronizer resets to 1, so a line held low through reset would look like a
  // fresh falling edge; r_armed blocks starts until a genuine high has been sampled.
  assign w_start = r_armed & r_rx_d & ~r_rx_s;

  // Input synchronizer, edge-detect delay and post-reset arming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
      r_flush <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= rx_in;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
      r_flush <= {r_flush[0], 1'b1};
      r_armed <= r_armed | (r_flush[1] & r_rx_s);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_idx_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_START;
          w_cnt_clr   = 1'b1;
          w_idx_clr   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_clr = 1'b1;
          if (r_rx_s) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
          if (r_rx_s) begin
            w_load = 1'b1;
          end else begin
            w_ferr = 1'b1;
          end
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bit-period counter, bit index and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
      r_shift <= {NUM_BITS{1'b0}};
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_idx_clr) begin
        r_idx <= {IDX_W{1'b0}};
      end else if (w_shift_en) begin
        r_idx <= r_idx + IDX_W'(1);
      end else begin
        r_idx <= r_idx;
      end
      if (w_shift_en) begin
        r_shift <= {r_rx_s, r_shift[NUM_BITS-1:1]};
      end else begin
        r_shift <= r_shift;
      end
    end
  end

  // Registered outputs; the pulses last exactly one cycle because the strobes do
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= {NUM_BITS{1'b0}};
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_word  <= w_load ? r_shift : r_word;
      r_valid <= w_load;
      r_ferr  <= w_ferr;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames with expected pulses/words, plus
// hand-written glitch and mid-frame reset sequences.
module tb_uart_rx;

  localparam int C  = 16;
  localparam int NB = 8;
  // rx_in driven right after posedge n: 2 sync flops, half bit, 9 bit periods, output register
  localparam int PULSE_LAT = 2 + C/2 + (NB+1)*C + 1;

  logic          clk;
  logic          rst_n;
  logic          rx_in;
  logic [NB-1:0] word_out;
  logic          word_valid;
  logic          frame_err;
  logic          busy;

  int n_tests;
  int n_fail;
  int cyc;
  int valid_hi;
  int ferr_hi;
  int overlap;
  int last_valid_cyc;
  int last_ferr_cyc;

  uart_rx #(.NUM_BITS(NB), .CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (word_valid) begin
      valid_hi       <= valid_hi + 1;
      last_valid_cyc <= cyc;
    end
    if (frame_err) begin
      ferr_hi       <= ferr_hi + 1;
      last_ferr_cyc <= cyc;
    end
    if (word_valid && frame_err) overlap <= overlap + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_word;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns C*(NB+2) cycles later with the line high.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int start_cyc);
    start_cyc = cyc;
    rx_in = 1'b0;
    wait_cyc(C);
    for (int k = 0; k < NB; k++) begin
      rx_in = d[k];
      wait_cyc(C);
    end
    rx_in = stop;
    wait_cyc(C);
    rx_in = 1'b1;
  endtask

  initial begin
    int s;
    int v0;
    int f0;
    int fall_cyc;
    logic seen_busy;
    logic [7:0] d81;

    n_tests = 0; n_fail = 0; cyc = 0;
    valid_hi = 0; ferr_hi = 0; overlap = 0;
    last_valid_cyc = 0; last_ferr_cyc = 0;
    rst_n = 1'b0;
    rx_in = 1'b1;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 10, exp_valid: 1, exp_ferr: 0, exp_word: 8'hA5};
    vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0,  exp_valid: 1, exp_ferr: 0, exp_word: 8'h00};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: 10, exp_valid: 1, exp_ferr: 0, exp_word: 8'hFF};
    vecs[3] = '{data: 8'h3C, stop: 1'b0, gap: 20, exp_valid: 0, exp_ferr: 1, exp_word: 8'hFF};
    vecs[4] = '{data: 8'h42, stop: 1'b1, gap: 10, exp_valid: 1, exp_ferr: 0, exp_word: 8'h42};

    wait_cyc(3);
    check("reset word_out", {24'd0, word_out}, 32'h0);
    check("reset word_valid", {31'd0, word_valid}, 32'h0);
    check("reset frame_err", {31'd0, frame_err}, 32'h0);
    check("reset busy", {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    wait_cyc(8);

    for (int i = 0; i < 5; i++) begin
      v0 = valid_hi;
      f0 = ferr_hi;
      send_frame(vecs[i].data, vecs[i].stop, s);
      check($sformatf("vec%0d valid cycles", i), valid_hi - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d ferr cycles", i), ferr_hi - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d word_out", i), {24'd0, word_out}, {24'd0, vecs[i].exp_word});
      if (vecs[i].exp_valid == 1)
        check($sformatf("vec%0d valid latency", i), last_valid_cyc - s, PULSE_LAT);
      else
        check($sformatf("vec%0d ferr latency", i), last_ferr_cyc - s, PULSE_LAT);
      if (vecs[i].gap > 0) wait_cyc(vecs[i].gap);
    end

    // 5-cycle glitch on an idle line
    v0 = valid_hi;
    f0 = ferr_hi;
    s = cyc;
    rx_in = 1'b0;
    seen_busy = 1'b0;
    fall_cyc = -1;
    for (int j = 0; j < 25; j++) begin
      if (j == 5) rx_in = 1'b1;
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
      if (seen_busy && !busy && fall_cyc < 0) fall_cyc = cyc;
      @(posedge clk);
      #1;
    end
    check("glitch busy rose", {31'd0, seen_busy}, 32'h1);
    // busy must drop within 10 cycles of rx_s falling (2 cycles after rx_in)
    check("glitch busy fell in time", {31'd0, (fall_cyc >= 0 && fall_cyc - s <= 12)}, 32'h1);
    check("glitch no valid", valid_hi - v0, 32'h0);
    check("glitch no ferr", ferr_hi - f0, 32'h0);
    wait_cyc(10);

    // Reset during data bit 3 of 0x81
    d81 = 8'h81;
    s = cyc;
    rx_in = 1'b0;
    wait_cyc(C);
    for (int k = 0; k < 3; k++) begin
      rx_in = d81[k];
      wait_cyc(C);
    end
    rx_in = d81[3];
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst word_out", {24'd0, word_out}, 32'h0);
    check("async rst word_valid", {31'd0, word_valid}, 32'h0);
    check("async rst frame_err", {31'd0, frame_err}, 32'h0);
    check("async rst busy", {31'd0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    v0 = valid_hi;
    f0 = ferr_hi;
    wait_cyc(6);
    check("post-rst busy low line", {31'd0, busy}, 32'h0);
    for (int k = 4; k < NB; k++) begin
      rx_in = d81[k];
      wait_cyc(C);
    end
    rx_in = 1'b1;
    wait_cyc(C + 20);
    check("aborted frame no valid", valid_hi - v0, 32'h0);
    check("aborted frame no ferr", ferr_hi - f0, 32'h0);

    v0 = valid_hi;
    send_frame(8'h18, 1'b1, s);
    check("post-rst 0x18 valid", valid_hi - v0, 32'h1);
    check("post-rst 0x18 word", {24'd0, word_out}, 32'h18);
    check("post-rst 0x18 latency", last_valid_cyc - s, PULSE_LAT);
    wait_cyc(5);

    check("valid/ferr overlap", overlap, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
